// File: rtl/clk_rst_seq_pkg.sv
// clk_rst_seq_pkg: state encoding and parameter checks for the clock/reset sequencer
package clk_rst_seq_pkg;
  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_GATE    = 3'd1,
    ST_ASSERT  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } seq_state_e;
  localparam logic [2:0] SC_RUN     = 3'd0;
  localparam logic [2:0] SC_GATE    = 3'd1;
  localparam logic [2:0] SC_ASSERT  = 3'd2;
  localparam logic [2:0] SC_RELEASE = 3'd3;
  localparam logic [2:0] SC_DONE    = 3'd4;
  function automatic bit dly_ok(input int cnt_w, input int g, input int a, input int d);
    longint lim;
    lim = longint'(1) << cnt_w;
    return g >= 1 && a >= 1 && d >= 1 && g < lim && a < lim && d < lim;
  endfunction
endpackage

// File: rtl/clk_rst_prio_enc.sv
// clk_rst_prio_enc: lowest-set-bit one-hot priority encoder
module clk_rst_prio_enc #(
  parameter int NUM_DOM = 4
) (
  input  logic [NUM_DOM-1:0] req,
  output logic [NUM_DOM-1:0] grant,
  output logic               valid
);
  assign grant = req & (~req + NUM_DOM'(1));
  assign valid = |req;
endmodule

// File: rtl/clk_rst_seq.sv
// clk_rst_seq: gates clocks, holds and staggers release of per-domain resets
module clk_rst_seq
  import clk_rst_seq_pkg::*;
#(
  parameter int NUM_DOM      = 4,
  parameter int CNT_W        = 8,
  parameter int GATE_DLY     = 2,
  parameter int ASSERT_HOLD  = 8,
  parameter int DEASSERT_DLY = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sw_rst_req,
  input  logic [NUM_DOM-1:0] sw_rst_dom_mask,
  output logic               sw_rst_ack,
  output logic [NUM_DOM-1:0] dom_clk_en,
  output logic [NUM_DOM-1:0] dom_rst_n,
  output logic               seq_busy,
  output logic [2:0]         seq_state
);
  localparam logic [CNT_W-1:0] G_END = CNT_W'(GATE_DLY - 1);
  localparam logic [CNT_W-1:0] A_END = CNT_W'(ASSERT_HOLD - 1);
  localparam logic [CNT_W-1:0] D_END = CNT_W'(DEASSERT_DLY - 1);

  if (!dly_ok(CNT_W, GATE_DLY, ASSERT_HOLD, DEASSERT_DLY)) begin : g_bad_dly
    $error("clk_rst_seq: delay parameter out of range");
  end

  seq_state_e         state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [NUM_DOM-1:0] mask_q, mask_d, pend, pend_d, grant, rst_n_d, clk_en_d;
  logic               por_q, por_d, zreq_q, zreq_d, ack_d, valid;

  clk_rst_prio_enc #(.NUM_DOM(NUM_DOM)) u_enc (
    .req  (pend),
    .grant(grant),
    .valid(valid)
  );

  // outputs are computed from the current state and registered, so they lag state by one cycle
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    mask_d   = mask_q;
    pend_d   = pend;
    por_d    = por_q;
    zreq_d   = 1'b0;
    rst_n_d  = dom_rst_n;
    clk_en_d = dom_clk_en;
    ack_d    = zreq_q;
    case (state)
      ST_RUN: begin
        rst_n_d  = '1;
        clk_en_d = '1;
        if (sw_rst_req && |sw_rst_dom_mask) begin
          mask_d  = sw_rst_dom_mask;
          por_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_GATE;
        end
        zreq_d = sw_rst_req && ~|sw_rst_dom_mask;
      end
      ST_GATE: begin
        clk_en_d = ~mask_q;
        cnt_d    = (cnt == G_END) ? '0 : cnt + 1'b1;
        state_d  = (cnt == G_END) ? ST_ASSERT : ST_GATE;
      end
      ST_ASSERT: begin
        rst_n_d  = dom_rst_n & ~mask_q;
        clk_en_d = dom_clk_en | mask_q;
        cnt_d    = (cnt == A_END) ? '0 : cnt + 1'b1;
        pend_d   = (cnt == A_END) ? mask_q : pend;
        state_d  = (cnt == A_END) ? ST_RELEASE : ST_ASSERT;
      end
      ST_RELEASE: begin
        rst_n_d  = ~pend;
        clk_en_d = '1;
        cnt_d    = (cnt == D_END) ? '0 : cnt + 1'b1;
        pend_d   = (cnt == D_END) ? pend & ~grant : pend;
        state_d  = valid ? ST_RELEASE : ST_DONE;
      end
      ST_DONE: begin
        rst_n_d  = '1;
        clk_en_d = '1;
        ack_d    = ~por_q;
        state_d  = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ASSERT;
      cnt        <= '0;
      mask_q     <= '1;
      pend       <= '0;
      por_q      <= 1'b1;
      zreq_q     <= 1'b0;
      dom_rst_n  <= '0;
      dom_clk_en <= '0;
      sw_rst_ack <= 1'b0;
      seq_busy   <= 1'b1;
      seq_state  <= SC_ASSERT;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      mask_q     <= mask_d;
      pend       <= pend_d;
      por_q      <= por_d;
      zreq_q     <= zreq_d;
      dom_rst_n  <= rst_n_d;
      dom_clk_en <= clk_en_d;
      sw_rst_ack <= ack_d;
      seq_busy   <= state != ST_RUN;
      seq_state  <= state;
    end
  end
endmodule

// File: tb/tb_clk_rst_seq.sv
// tb_clk_rst_seq: scoreboard bench for the clock/reset sequencer
module tb_clk_rst_seq;
  import clk_rst_seq_pkg::*;
  localparam int G = 2, H = 8, D = 16;
  localparam logic [12:0] RSTV = {SC_ASSERT, 1'b1, 1'b0, 4'h0, 4'h0};

  logic clk = 1'b0, rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [3:0] m0 = 4'h0, m1 = 4'h0;
  logic ack0, ack1, busy0, busy1;
  logic [3:0] ce0, ce1, rn0, rn1;
  logic [2:0] st0, st1;

  always #5 clk = ~clk;

  clk_rst_seq dut0 (
    .clk(clk), .rst(rst), .sw_rst_req(req0), .sw_rst_dom_mask(m0), .sw_rst_ack(ack0),
    .dom_clk_en(ce0), .dom_rst_n(rn0), .seq_busy(busy0), .seq_state(st0)
  );
  clk_rst_seq #(.DEASSERT_DLY(1)) dut1 (
    .clk(clk), .rst(rst), .sw_rst_req(req1), .sw_rst_dom_mask(m1), .sw_rst_ack(ack1),
    .dom_clk_en(ce1), .dom_rst_n(rn1), .seq_busy(busy1), .seq_state(st1)
  );

  typedef struct {
    int          cyc;
    int          inst;
    logic [12:0] exp;
    string       tag;
  } ent_t;
  ent_t sb[$];
  int cyc = 0, checks = 0, errors = 0;
  int t, e0;

  function automatic int ackoff(logic [3:0] m, int d);
    return G + 1 + H + d * $countones(m) + 1;
  endfunction

  // expected {state, busy, ack, clk_en, rst_n} at a given cycle offset after the request edge
  function automatic logic [12:0] model(int off, logic [3:0] m, bit por, int d);
    int a, r;
    logic [3:0] rn, ce;
    logic [2:0] st;
    a = ackoff(m, d);
    r = 0;
    rn = 4'hF;
    ce = (off >= 1 && off <= G) ? ~m : 4'hF;
    for (int i = 0; i < 4; i++)
      if (m[i]) begin
        if (off >= G + 1 && off < G + 1 + H + d * (r + 1)) rn[i] = 1'b0;
        r++;
      end
    st = off == 0 ? SC_RUN : off <= G ? SC_GATE : off <= G + H ? SC_ASSERT :
         off < a ? SC_RELEASE : off == a ? SC_DONE : SC_RUN;
    return {st, off >= 1 && off <= a, !por && off == a, ce, rn};
  endfunction

  task automatic push(input int c, input int inst, input logic [12:0] v, input string tag);
    ent_t e;
    e.cyc = c;
    e.inst = inst;
    e.exp = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic push_seq(input int base, input int inst, input logic [3:0] m, input bit por,
                          input int d, input int off0, input int off1, input string tag);
    for (int o = off0; o <= off1; o++) push(base + o, inst, model(o, m, por, d), tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      ent_t e;
      logic [12:0] obs;
      e = sb.pop_front();
      obs = (e.inst != 0) ? {st1, busy1, ack1, ce1, rn1} : {st0, busy0, ack0, ce0, rn0};
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s cyc %0d observed %h expected %h", e.tag, cyc, obs, e.exp);
      end
    end
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while (sb.size() > 0 && n < max) begin
      tick();
      n++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout observed %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    push(1, 0, RSTV, "reset0");
    push(1, 1, RSTV, "reset1");
    repeat (5) tick();
    rst = 1'b0;
    e0 = cyc + 1;
    push_seq(e0 - G - 1, 0, 4'hF, 1'b1, D, G + 1, ackoff(4'hF, D) + 2, "por");
    drain(200);

    t = cyc + 1;
    push_seq(t, 0, 4'b0101, 1'b0, D, 0, ackoff(4'b0101, D) + 1, "sw0101");
    req0 = 1'b1; m0 = 4'b0101;
    tick();
    req0 = 1'b0; m0 = 4'h0;
    drain(100);

    t = cyc + 1;
    for (int o = 0; o <= 3; o++) push(t + o, 0, {SC_RUN, 1'b0, o == 1, 4'hF, 4'hF}, "zero_mask");
    req0 = 1'b1; m0 = 4'h0;
    tick();
    req0 = 1'b0;
    drain(10);

    t = cyc + 1;
    push_seq(t, 0, 4'b0101, 1'b0, D, 0, ackoff(4'b0101, D) + 1, "busy_req");
    req0 = 1'b1; m0 = 4'b0101;
    tick();
    req0 = 1'b0; m0 = 4'h0;
    repeat (19) tick();
    req0 = 1'b1; m0 = 4'hF;
    tick();
    req0 = 1'b0; m0 = 4'h0;
    drain(100);

    t = cyc + 1;
    push_seq(t, 1, 4'b1000, 1'b0, 1, 0, ackoff(4'b1000, 1) + 1, "skip");
    req1 = 1'b1; m1 = 4'b1000;
    tick();
    req1 = 1'b0; m1 = 4'h0;
    drain(40);

    t = cyc + 1;
    push_seq(t, 0, 4'b0101, 1'b0, D, 0, 26, "mid");
    req0 = 1'b1; m0 = 4'b0101;
    tick();
    req0 = 1'b0; m0 = 4'h0;
    repeat (26) tick();
    rst = 1'b1;
    push(t + 27, 0, RSTV, "mid_rst");
    push(t + 28, 0, RSTV, "mid_rst_hold");
    tick();
    tick();
    rst = 1'b0;
    e0 = cyc + 1;
    push_seq(e0 - G - 1, 0, 4'hF, 1'b1, D, G + 1, ackoff(4'hF, D) + 2, "por_rerun");
    drain(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clk_rst_seq.md
Name: clk_rst_seq

Overview:
- Clock/reset sequencer that drives the per-domain reset and clock-enable signals carried by the codebase's clock/reset interface; it is the producing end of that interface.
- Runs a power-on sequence after `rst`, and a software-requested masked sequence on demand.
- Each sequence gates clocks, holds reset, then releases domains in ascending index order with a fixed stagger.
- Sits at the top of the design, one instance per clock tree.

Parameters:
- NUM_DOM, 4: number of downstream reset/clock domains.
- CNT_W, 8: delay counter width; every delay parameter must be below 2**CNT_W.
- GATE_DLY, 2: cycles clocks are gated before reset is asserted (>=1).
- ASSERT_HOLD, 8: cycles reset is held with clocks running (>=1).
- DEASSERT_DLY, 16: cycles between successive domain releases (>=1).

Ports:
- clk, in, 1: single clock.
- rst, in, 1: reset, synchronous, active-high.
- sw_rst_req, in, 1: software sequence request, sampled only in RUN.
- sw_rst_dom_mask, in, NUM_DOM: domains affected by the request, sampled with sw_rst_req.
- sw_rst_ack, out, 1: one-cycle pulse when a software sequence completes.
- dom_clk_en, out, NUM_DOM: per-domain clock enable.
- dom_rst_n, out, NUM_DOM: per-domain reset, active-low.
- seq_busy, out, 1: high whenever state != RUN.
- seq_state, out, 3: current state code.

Behaviour:
- State codes: RUN=0, GATE=1, ASSERT=2, RELEASE=3, DONE=4.
- While rst=1:
  - state=ASSERT, mask_q=all ones, por_q=1, cnt=0.
  - dom_rst_n=0, dom_clk_en=0, sw_rst_ack=0, seq_busy=1.
- rst asserted mid-sequence aborts immediately to the values above. No ack is issued for the aborted request.
- RUN:
  - Outputs idle: rst_n all 1, clk_en all 1.
  - sw_rst_req=1 with nonzero mask: latch mask_q, set por_q=0, go to GATE.
  - sw_rst_req=1 with zero mask: sw_rst_ack=1 on the next cycle, state stays RUN, no outputs change.
- GATE:
  - dom_clk_en[i]=0 for every i in mask_q; dom_rst_n unchanged.
  - Lasts GATE_DLY cycles, then go to ASSERT.
- ASSERT:
  - dom_rst_n[i]=0 and dom_clk_en[i]=1 for every i in mask_q, so domain synchronous resets see clock edges.
  - Lasts ASSERT_HOLD cycles, counted from the first cycle with rst=0 in the power-on case. Then go to RELEASE with pend=mask_q and cnt=0.
- RELEASE:
  - cnt counts to DEASSERT_DLY.
  - On expiry, the lowest set bit k of pend releases: dom_rst_n[k]=1, pend[k] clears, cnt=0.
  - Unmasked indices are skipped at zero cost.
  - When pend becomes 0, go to DONE.
- DONE:
  - Lasts one cycle.
  - sw_rst_ack=1 only if por_q=0.
  - Next state is RUN.
- Sequence requests arriving while busy are ignored, not queued.
- Domains outside mask_q never change during a software sequence.
- All outputs are registered; no combinational input-to-output path.
- Counter compares are exact equality. cnt resets to 0 on every state entry, so it cannot wrap.

Decomposition:
- clk_rst_seq_pkg holds:
  - the seq_state_e enum (3-bit codes above);
  - the state-code constants used by the bench;
  - a function checking delay parameters against CNT_W, evaluated in an elaboration-time assertion.
- One sub-module, clk_rst_prio_enc:
  - parameterised NUM_DOM-bit lowest-set-bit encoder;
  - outputs a one-hot grant plus a valid flag;
  - used by RELEASE to choose the next domain.

Test Plan:
- Power-on, defaults: rst high 5 cycles, then low. dom_clk_en=4'hF from the first edge with rst low. dom_rst_n bits rise 24/40/56/72 cycles after that edge for i=0..3. DONE occurs at 73 with no ack. seq_busy falls at 74.
- Software request, mask 4'b0101, req pulse at edge T in RUN:
  - dom_clk_en=4'b1010 over T+1..T+2;
  - dom_rst_n=4'b1010 from T+3;
  - dom_rst_n[0] rises at T+27, dom_rst_n[2] at T+43;
  - sw_rst_ack pulses at T+44;
  - dom_*[1] and dom_*[3] stay 1 throughout.
- Zero-mask request: sw_rst_ack pulses one cycle later, seq_busy stays 0, no output toggles.
- Request during busy (mask 4'hF injected in RELEASE): ignored. The sequence completes exactly as the original mask, with a single ack.
- rst asserted at the midpoint of RELEASE during a software sequence: all outputs take their reset values on the next edge. The power-on sequence reruns, and no sw_rst_ack is issued.
- Mask 4'b1000 with DEASSERT_DLY=1: dom_rst_n[3] releases 1 cycle after RELEASE entry, confirming the zero-cost skip of bits 0..2.
